pool_ctrl: RTL

Job sequencer for the streaming max-pooling datapath. It takes a feature-map job (dimensions, kernel, stride, source/destination base addresses) and reads each pooling window from the activation buffer in raster order. It streams the pixels into the pooling unit's data_in/valid_in port and writes each pooled result to the output buffer. It sits between the layer scheduler, the activation SRAM read port, the pooling unit and the output SRAM write port.

---
 rtl/pool_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pool_ctrl.sv
// Job sequencer for the streaming max-pooling datapath: walks each pooling
// window in raster order, feeds the pooling unit and stores pooled results.
module pool_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [DIM_WIDTH-1:0]         cfg_width,
  input  logic [DIM_WIDTH-1:0]         cfg_height,
  input  logic [1:0]                   cfg_kernel,
  input  logic [1:0]                   cfg_stride,
  input  logic [ADDR_WIDTH-1:0]        cfg_src_base,
  input  logic [ADDR_WIDTH-1:0]        cfg_dst_base,
  input  logic                         stall,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         pool_start,
  output logic                         pool_enable,
  output logic [1:0]                   pool_kernel,
  output logic signed [DATA_WIDTH-1:0] pool_data,
  output logic                         pool_valid,
  input  logic signed [DATA_WIDTH-1:0] pool_result,
  input  logic                         pool_result_valid,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data
);

  localparam int EW = DIM_WIDTH + 2;
  localparam int PW = 2 * EW;
  localparam int CW = 2 * DIM_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DIM_WIDTH-1:0]  w_q, h_q;
  logic [1:0]            k_q, s_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;

  logic [EW-1:0] x0, y0;
  logic [1:0]    kx, ky;
  logic [CW-1:0] issued, written;

  logic                         vld_p1;
  logic                         wr_en_p1;
  logic [ADDR_WIDTH-1:0]        wr_addr_p1;
  logic signed [DATA_WIDTH-1:0] wr_data_p1;

  logic [EW-1:0]         w_e, h_e, k_e, s_e, row, col;
  logic [PW-1:0]         row_off;
  logic [1:0]            k_m1;
  logic                  cfg_ok, win_last, x_wrap, y_end, drained, res_acc;
  logic [ADDR_WIDTH-1:0] rd_addr_calc, wr_addr_calc;

  // Widened to DIM_WIDTH+2 so origin + stride + kernel never overflows.
  assign w_e  = EW'(w_q);
  assign h_e  = EW'(h_q);
  assign k_e  = EW'(k_q);
  assign s_e  = EW'(s_q);
  assign k_m1 = k_q - 2'd1;

  assign cfg_ok = ((cfg_kernel == 2'd2) || (cfg_kernel == 2'd3)) &&
                  (cfg_stride != 2'd0) &&
                  (EW'(cfg_width) >= EW'(cfg_kernel)) &&
                  (EW'(cfg_height) >= EW'(cfg_kernel));

  assign win_last = (kx == k_m1) && (ky == k_m1);
  assign x_wrap   = (x0 + s_e + k_e) > w_e;
  assign y_end    = (y0 + s_e + k_e) > h_e;

  assign row          = y0 + EW'(ky);
  assign col          = x0 + EW'(kx);
  assign row_off      = PW'(row) * PW'(w_e);
  assign rd_addr_calc = src_q + ADDR_WIDTH'(row_off) + ADDR_WIDTH'(col);
  assign wr_addr_calc = dst_q + ADDR_WIDTH'(written);

  assign drained = (written == issued) && !vld_p1 && !pool_result_valid;
  assign res_acc = pool_result_valid && ((state == S_READ) || (state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    rd_en       = 1'b0;
    pool_start  = 1'b0;
    pool_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) state_nxt = cfg_ok ? S_INIT : S_DONE;
      end
      S_INIT: begin
        busy        = 1'b1;
        pool_enable = 1'b1;
        pool_start  = 1'b1;
        state_nxt   = S_READ;
      end
      S_READ: begin
        busy        = 1'b1;
        pool_enable = 1'b1;
        rd_en       = !stall;
        if (!stall && win_last && x_wrap && y_end) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        pool_enable = 1'b1;
        if (drained) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cfg_start) begin
      w_q   <= cfg_width;
      h_q   <= cfg_height;
      k_q   <= cfg_kernel;
      s_q   <= cfg_stride;
      src_q <= cfg_src_base;
      dst_q <= cfg_dst_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err        <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      kx         <= '0;
      ky         <= '0;
      issued     <= '0;
      written    <= '0;
      vld_p1     <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      // p0 -> p1: read strobe becomes pixel-valid alongside returning SRAM data
      vld_p1   <= rd_en;
      wr_en_p1 <= res_acc;
      if (state == S_IDLE && cfg_start) err <= !cfg_ok;
      if (state == S_INIT) begin
        x0      <= '0;
        y0      <= '0;
        kx      <= '0;
        ky      <= '0;
        issued  <= '0;
        written <= '0;
      end else if (rd_en) begin
        if (kx == k_m1) begin
          kx <= '0;
          if (ky == k_m1) begin
            ky     <= '0;
            issued <= issued + CW'(1);
            if (x_wrap) begin
              x0 <= '0;
              y0 <= y0 + s_e;
            end else begin
              x0 <= x0 + s_e;
            end
          end else begin
            ky <= ky + 2'd1;
          end
        end else begin
          kx <= kx + 2'd1;
        end
      end
      // p0 -> p1: pooled result registered into the output SRAM write port
      if (res_acc) begin
        wr_addr_p1 <= wr_addr_calc;
        wr_data_p1 <= pool_result;
        written    <= written + CW'(1);
      end
    end
  end

  assign rd_addr     = rd_en ? rd_addr_calc : '0;
  assign pool_kernel = pool_enable ? k_q : 2'd0;
  assign pool_valid  = vld_p1;
  assign pool_data   = vld_p1 ? rd_data : '0;
  assign wr_en       = wr_en_p1;
  assign wr_addr     = wr_addr_p1;
  assign wr_data     = wr_data_p1;

endmodule
